// File: rtl/serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_tx
// Purpose  : Moore serial pattern transmitter. Accepts a WIDTH-bit word and a
//            repeat count over a valid/ready handshake, then shifts the word
//            out MSB-first (reps+1) times back-to-back and pulses done.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_reps,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  // Bit counter only needs to index WIDTH positions; keep at least one bit.
  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] c_LAST_BIT = BC_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_saved;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [BC_W-1:0]  r_bit_cnt;
  logic             w_last_bit;
  logic             w_rep_zero;

  assign w_last_bit = (r_bit_cnt == c_LAST_BIT);
  assign w_rep_zero = (r_rep_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs; out also uses the registered MSB.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    out         = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out       = r_shift[WIDTH-1];
        out_valid = 1'b1;
        busy      = 1'b1;
        if (w_last_bit && w_rep_zero) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, shift each SHIFT cycle, reload between
  // repetitions so the next frame follows with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_saved   <= '0;
      r_rep_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_valid) begin
            r_shift   <= load_data;
            r_saved   <= load_data;
            r_rep_cnt <= load_reps;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_bit_cnt <= '0;
            if (!w_rep_zero) begin
              r_shift   <= r_saved;
              r_rep_cnt <= r_rep_cnt - 1'b1;
            end else begin
              r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_tx
// Purpose  : Self-checking bench for serial_pattern_tx. A frame-level model
//            predicts the per-cycle outputs; directed tests add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_tx;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] load_reps;
  logic             s_ready, s_out, s_valid, s_busy, s_done;

  serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_reps  (load_reps),
    .load_ready (s_ready),
    .out        (s_out),
    .out_valid  (s_valid),
    .busy       (s_busy),
    .done       (s_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model: per-cycle expected outputs -----------------------
  // Tuple order: {out, out_valid, load_ready, busy, done}
  localparam logic [4:0] c_IDLE = 5'b00100;
  localparam logic [4:0] c_DONE = 5'b00011;
  logic [4:0] exp_q[$];
  logic [4:0] exp_cur;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_cur = c_IDLE;
    end else begin
      if (exp_cur == c_IDLE && load_valid) begin
        for (int f = 0; f <= int'(load_reps); f++)
          for (int b = WIDTH - 1; b >= 0; b--)
            exp_q.push_back({load_data[b], 1'b1, 1'b0, 1'b1, 1'b0});
        exp_q.push_back(c_DONE);
      end
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else                  exp_cur = c_IDLE;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) chk("cycle_outputs", {59'd0, s_out, s_valid, s_ready, s_busy, s_done},
                    {59'd0, exp_cur});
  end

  // ---------------- monitor: captured stream --------------------------------
  logic cap_bits[0:511];
  int   cap_n, done_n, gap_run, last_gap;
  logic seen_valid;

  always @(negedge clk) begin
    if (s_valid) begin
      if (cap_n < 512) cap_bits[cap_n] = s_out;
      cap_n++;
      if (seen_valid && gap_run > 0) last_gap = gap_run;
      gap_run    = 0;
      seen_valid = 1'b1;
    end else begin
      gap_run++;
    end
    if (s_done) done_n++;
  end

  task automatic clr();
    cap_n = 0; done_n = 0; gap_run = 0; last_gap = -1; seen_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Wait until done is seen; k counts cycles since the accept edge.
  task automatic wait_done(input int lim, inout int k);
    while (!s_done && k < lim) begin
      tick();
      k++;
    end
    if (!s_done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] cap_word(input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w = {w[62:0], cap_bits[i]};
    return w;
  endfunction

  initial begin
    int k;
    logic [31:0] mask;
    int bad;
    logic [3:0] pat;
    clr();
    // ---------------- reset with load_valid asserted --------------------------
    rst = 1'b1; load_valid = 1'b1; load_data = 4'b1010; load_reps = '0;
    tick(); tick();
    chk("rst_out",        {63'd0, s_out},   64'd0);
    chk("rst_out_valid",  {63'd0, s_valid}, 64'd0);
    chk("rst_load_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_busy",       {63'd0, s_busy},  64'd0);
    chk("rst_done",       {63'd0, s_done},  64'd0);
    chk_en = 1'b1;
    rst = 1'b0; load_valid = 1'b0;
    tick();

    // ---------------- single frame -------------------------------------------
    clr();
    load_valid = 1'b1; load_data = 4'b1010; load_reps = 4'd0;
    tick(); k = 1; load_valid = 1'b0;
    wait_done(50, k);
    chk("single_done_cycle", 64'(k), 64'd5);
    tick();
    chk("single_ready_after", {63'd0, s_ready}, 64'd1);
    chk("single_bits", cap_word(4), 64'b1010);
    chk("single_nbits", 64'(cap_n), 64'd4);

    // ---------------- repeat x3 with busy-time load attempt -------------------
    clr();
    load_valid = 1'b1; load_data = 4'b1010; load_reps = 4'd2;
    tick(); k = 1;
    load_data = 4'b1111; load_reps = 4'd0;   // held valid while busy
    wait_done(100, k);
    chk("rep_done_cycle", 64'(k), 64'd13);
    chk("rep_bits", cap_word(12), 64'b101010101010);
    chk("rep_nbits", 64'(cap_n), 64'd12);
    chk("rep_gapless", 64'(last_gap), 64'hFFFF_FFFF_FFFF_FFFF);
    mask = '0;
    for (int i = 3; i < 12; i++)
      if ({cap_bits[i-3], cap_bits[i-2], cap_bits[i-1], cap_bits[i]} == 4'b1010)
        mask[i+1] = 1'b1;
    chk("rep_detector_hits", {32'd0, mask}, 64'h1550);
    clr();
    tick();
    chk("busy_load_ready_idle", {63'd0, s_ready}, 64'd1);
    tick(); k = 1;
    load_valid = 1'b0;
    wait_done(50, k);
    chk("deferred_load_bits", cap_word(4), 64'b1111);
    chk("deferred_load_done", 64'(done_n), 64'd1);
    tick();

    // ---------------- reset mid-frame ----------------------------------------
    clr();
    load_valid = 1'b1; load_data = 4'b1100; load_reps = 4'd3;
    tick(); load_valid = 1'b0;
    tick();                                    // bit 2 on out
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_out_valid",  {63'd0, s_valid}, 64'd0);
    chk("midrst_load_ready", {63'd0, s_ready}, 64'd1);
    chk("midrst_busy",       {63'd0, s_busy},  64'd0);
    repeat (20) tick();
    chk("midrst_no_done", 64'(done_n), 64'd0);
    chk("midrst_nbits", 64'(cap_n), 64'd2);

    // ---------------- back-to-back, max reps ----------------------------------
    clr();
    load_valid = 1'b1; load_data = 4'b1001; load_reps = 4'd15;
    k = 0;
    while (done_n < 2 && k < 400) begin
      tick();
      k++;
    end
    load_valid = 1'b0;
    chk("b2b_done_count", 64'(done_n), 64'd2);
    chk("b2b_nbits", 64'(cap_n), 64'd128);
    chk("b2b_gap", 64'(last_gap), 64'd2);
    pat = 4'b1001;
    bad = 0;
    for (int i = 0; i < 128; i++)
      if (cap_bits[i] !== pat[3 - (i % 4)]) bad++;
    chk("b2b_pattern_errors", 64'(bad), 64'd0);
    repeat (4) tick();
    chk("b2b_no_third", 64'(done_n), 64'd2);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
